// File: rtl/dvp_pkg.sv
// Shared constants for the DVP pattern transmitter: FSM encoding, pattern codes
// and the RGB565 colour-bar table.
package dvp_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_VBP    = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_HBLANK = 3'd4;
    localparam logic [2:0] ST_VFP    = 3'd5;

    localparam logic [1:0] PAT_BARS   = 2'd0;
    localparam logic [1:0] PAT_RAMP   = 2'd1;
    localparam logic [1:0] PAT_CHECK  = 2'd2;
    localparam logic [1:0] PAT_SOLID  = 2'd3;
    localparam logic [1:0] PAT_STREAM = 2'd3;

    // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
    localparam logic [7:0][15:0] BAR_TABLE = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        return BAR_TABLE[idx];
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB565 test-pattern generator: (x, y, sel, frame_count) -> pixel.
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  sel,
    input  logic [15:0] frame_count,
    output logic [15:0] pixel
);

    localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);

    logic [2:0] bar_idx;
    logic       unused_y;

    // Only y[3] drives the checker; the other row bits are intentionally ignored.
    assign unused_y = ^{y[15:4], y[2:0]};

    always_comb begin
        bar_idx = 3'(x / BAR_W);
        case (sel)
            PAT_BARS:  pixel = bar_color(bar_idx);
            PAT_RAMP:  pixel = {x[4:0], x[5:0], x[4:0]};
            PAT_CHECK: pixel = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
            default:   pixel = frame_count;
        endcase
    end

endmodule

// File: rtl/dvp_pattern_tx.sv
// DVP (8-bit RGB565) test-pattern transmitter with VSYNC/HREF framing.
// Define DVP_PATTERN_TX_STREAM_EN to add a 16-bit pixel sink replacing pattern code 3.
module dvp_pattern_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 17,
    parameter int V_FP     = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
`ifdef DVP_PATTERN_TX_STREAM_EN
    input  logic [15:0] sink_data,
    input  logic        sink_valid,
    output logic        sink_ready,
    output logic        underflow,
`endif
    output logic        dvp_pclk,
    output logic [7:0]  dvp_data,
    output logic        dvp_href,
    output logic        dvp_vsync,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam logic [15:0] SLOT_LAST = 16'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0] ACT_LAST  = 16'(2 * H_ACTIVE - 1);
    localparam logic [15:0] VS_LAST   = 16'(V_SYNC - 1);
    localparam logic [15:0] VBP_LAST  = 16'(V_BP - 1);
    localparam logic [15:0] VA_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] VFP_LAST  = 16'(V_FP - 1);

    logic [2:0]  state;
    logic        phase;
    logic [15:0] slot_cnt;
    logic [15:0] line_cnt;
    logic [1:0]  sel_q;
    logic        line_end;
    logic        frame_end;
    logic        vs_entry;
    logic [15:0] gen_pixel;
    logic [15:0] pixel;

    // A slot closes on its second (pclk-high) cycle; framing only moves then.
    assign line_end  = phase && (slot_cnt == SLOT_LAST);
    assign frame_end = line_end && (state == ST_VFP) && (line_cnt == VFP_LAST);
    assign vs_entry  = enable && ((state == ST_IDLE) || frame_end);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            phase       <= 1'b0;
            slot_cnt    <= '0;
            line_cnt    <= '0;
            sel_q       <= PAT_BARS;
            frame_count <= '0;
        end else begin
            if (vs_entry)
                sel_q <= pattern_sel;
            if (state == ST_IDLE) begin
                phase    <= 1'b0;
                slot_cnt <= '0;
                line_cnt <= '0;
                if (enable)
                    state <= ST_VSYNC;
            end else begin
                phase <= ~phase;
                if (phase && state == ST_ACTIVE && slot_cnt == ACT_LAST)
                    state <= ST_HBLANK;
                if (line_end) begin
                    slot_cnt <= '0;
                    line_cnt <= line_cnt + 16'd1;
                    case (state)
                        ST_VSYNC: if (line_cnt == VS_LAST) begin
                            state    <= ST_VBP;
                            line_cnt <= '0;
                        end
                        ST_VBP: if (line_cnt == VBP_LAST) begin
                            state    <= ST_ACTIVE;
                            line_cnt <= '0;
                        end
                        ST_HBLANK: if (line_cnt == VA_LAST) begin
                            state    <= ST_VFP;
                            line_cnt <= '0;
                        end else begin
                            state <= ST_ACTIVE;
                        end
                        ST_VFP: if (line_cnt == VFP_LAST) begin
                            line_cnt    <= '0;
                            frame_count <= frame_count + 16'd1;
                            state       <= enable ? ST_VSYNC : ST_IDLE;
                        end
                        default: ;
                    endcase
                end else if (phase) begin
                    slot_cnt <= slot_cnt + 16'd1;
                end
            end
        end
    end

    dvp_pattern_gen #(
        .H_ACTIVE(H_ACTIVE)
    ) u_gen (
        .x          ({1'b0, slot_cnt[15:1]}),
        .y          (line_cnt),
        .sel        (sel_q),
        .frame_count(frame_count),
        .pixel      (gen_pixel)
    );

`ifdef DVP_PATTERN_TX_STREAM_EN
    logic [15:0] pix_p1;
    logic [15:0] stream_pix;

    assign sink_ready = (state == ST_ACTIVE) && !slot_cnt[0] && !phase && (sel_q == PAT_STREAM);

    // The accepted word drives the high byte immediately, then is held for the low byte.
    assign stream_pix = sink_ready ? (sink_valid ? sink_data : 16'h0000) : pix_p1;

    always_ff @(posedge clk) begin
        if (sink_ready)
            pix_p1 <= sink_valid ? sink_data : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            underflow <= 1'b0;
        else if (vs_entry)
            underflow <= 1'b0;
        else if (sink_ready && !sink_valid)
            underflow <= 1'b1;
    end

    assign pixel = (sel_q == PAT_STREAM) ? stream_pix : gen_pixel;
`else
    assign pixel = gen_pixel;
`endif

    assign busy      = (state != ST_IDLE);
    assign dvp_pclk  = busy && phase;
    assign dvp_href  = (state == ST_ACTIVE);
    assign dvp_vsync = (state == ST_VSYNC);

    always_comb begin
        dvp_data = 8'h00;
        if (dvp_href)
            dvp_data = slot_cnt[0] ? pixel[7:0] : pixel[15:8];
    end

endmodule
